// File: rtl/bs_decoder.sv
// Receive-side bitstream decoder: hunts SYNC, classifies the PID and deserializes
// data/token/handshake packets, then holds them for the protocol FSM until acknowledged.
module bs_decoder #(
    parameter int         DATA_BITS   = 88,
    parameter int         TOKEN_BITS  = 24,
    parameter int         HSHAKE_BITS = 8,
    parameter logic [7:0] SYNC_PAT    = 8'h80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_s_in,
    input  logic                   i_bit_valid,
    input  logic                   i_eop,
    input  logic                   i_pkt_ack,
    output logic [1:0]             o_pkt_type,
    output logic [DATA_BITS-1:0]   o_data,
    output logic [TOKEN_BITS-1:0]  o_token,
    output logic [HSHAKE_BITS-1:0] o_hshake,
    output logic                   o_pkt_valid,
    output logic                   o_pkt_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PID  = 3'd1;
    localparam logic [2:0] S_BODY = 3'd2;
    localparam logic [2:0] S_EOPW = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    localparam logic [1:0] T_NONE   = 2'b00;
    localparam logic [1:0] T_DATA   = 2'b01;
    localparam logic [1:0] T_TOKEN  = 2'b10;
    localparam logic [1:0] T_HSHAKE = 2'b11;

    localparam int DATA_IW  = $clog2(DATA_BITS);
    localparam int TOKEN_IW = $clog2(TOKEN_BITS);

    logic [2:0]             r_state;
    logic [6:0]             r_cnt;
    logic [7:0]             r_window;
    logic [7:0]             r_pid;
    logic [1:0]             r_kind;
    logic [6:0]             r_len;
    logic [1:0]             r_pktType;
    logic [DATA_BITS-1:0]   r_data;
    logic [TOKEN_BITS-1:0]  r_token;
    logic [HSHAKE_BITS-1:0] r_hshake;
    logic                   r_pktValid;
    logic                   r_pktErr;
    logic                   r_overrun;

    logic [7:0] w_windowNext;
    logic [7:0] w_pidNext;
    logic       w_pidOk;
    logic [1:0] w_pidKind;
    logic [6:0] w_cntInc;
    logic       w_bodyLast;

    assign w_windowNext = {i_s_in, r_window[7:1]};
    assign w_cntInc     = r_cnt + 7'd1;
    assign w_bodyLast   = (w_cntInc == r_len);
    assign w_pidOk      = (w_pidNext[7:4] == ~w_pidNext[3:0]);

    // PID as it will look once the incoming bit lands, so it can be judged on the 8th bit.
    always_comb begin
        w_pidNext = r_pid;
        w_pidNext[r_cnt[2:0]] = i_s_in;
    end

    always_comb begin
        case (w_pidNext[3:0])
            4'b0001, 4'b1001, 4'b1101: w_pidKind = T_TOKEN;
            4'b0011, 4'b1011:          w_pidKind = T_DATA;
            4'b0010, 4'b1010, 4'b1110: w_pidKind = T_HSHAKE;
            default:                   w_pidKind = T_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 7'd0;
            r_window   <= 8'd0;
            r_pid      <= 8'd0;
            r_kind     <= T_NONE;
            r_len      <= 7'd0;
            r_pktType  <= T_NONE;
            r_data     <= '0;
            r_token    <= '0;
            r_hshake   <= '0;
            r_pktValid <= 1'b0;
            r_pktErr   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_pktErr  <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_bit_valid) begin
                        if (w_windowNext == SYNC_PAT) begin
                            r_state  <= S_PID;
                            r_cnt    <= 7'd0;
                            r_window <= 8'd0;
                        end else begin
                            r_window <= w_windowNext;
                        end
                    end
                end
                S_PID: begin
                    if (i_bit_valid) begin
                        r_pid <= w_pidNext;
                        if (r_cnt == 7'd7) begin
                            r_cnt <= 7'd8;
                            if (!w_pidOk || w_pidKind == T_NONE) begin
                                r_pktErr <= 1'b1;
                                r_state  <= S_IDLE;
                                r_cnt    <= 7'd0;
                            end else if (w_pidKind == T_HSHAKE) begin
                                r_hshake <= w_pidNext;
                                r_kind   <= T_HSHAKE;
                                if (i_eop) begin
                                    r_state    <= S_HOLD;
                                    r_pktValid <= 1'b1;
                                    r_pktType  <= T_HSHAKE;
                                end else begin
                                    r_state <= S_EOPW;
                                end
                            end else if (i_eop) begin
                                r_pktErr <= 1'b1;
                                r_state  <= S_IDLE;
                                r_cnt    <= 7'd0;
                            end else begin
                                r_state <= S_BODY;
                                r_kind  <= w_pidKind;
                                if (w_pidKind == T_DATA) begin
                                    r_len       <= 7'(DATA_BITS);
                                    r_data[7:0] <= w_pidNext;
                                end else begin
                                    r_len        <= 7'(TOKEN_BITS);
                                    r_token[7:0] <= w_pidNext;
                                end
                            end
                        end else if (i_eop) begin
                            r_pktErr <= 1'b1;
                            r_state  <= S_IDLE;
                            r_cnt    <= 7'd0;
                        end else begin
                            r_cnt <= w_cntInc;
                        end
                    end else if (i_eop) begin
                        r_pktErr <= 1'b1;
                        r_state  <= S_IDLE;
                        r_cnt    <= 7'd0;
                    end
                end
                S_BODY: begin
                    if (i_bit_valid) begin
                        if (r_kind == T_DATA) r_data[r_cnt[DATA_IW-1:0]] <= i_s_in;
                        else                  r_token[r_cnt[TOKEN_IW-1:0]] <= i_s_in;
                        // The final bit is taken before a coincident eop, so the packet still completes.
                        if (w_bodyLast) begin
                            r_cnt <= 7'd0;
                            if (i_eop) begin
                                r_state    <= S_HOLD;
                                r_pktValid <= 1'b1;
                                r_pktType  <= r_kind;
                            end else begin
                                r_state <= S_EOPW;
                            end
                        end else if (i_eop) begin
                            r_pktErr <= 1'b1;
                            r_state  <= S_IDLE;
                            r_cnt    <= 7'd0;
                        end else begin
                            r_cnt <= w_cntInc;
                        end
                    end else if (i_eop) begin
                        r_pktErr <= 1'b1;
                        r_state  <= S_IDLE;
                        r_cnt    <= 7'd0;
                    end
                end
                S_EOPW: begin
                    r_cnt <= 7'd0;
                    if (i_bit_valid) begin
                        r_pktErr <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (i_eop) begin
                        r_state    <= S_HOLD;
                        r_pktValid <= 1'b1;
                        r_pktType  <= r_kind;
                    end
                end
                S_HOLD: begin
                    if (i_bit_valid) r_overrun <= 1'b1;
                    if (i_pkt_ack) begin
                        r_state    <= S_IDLE;
                        r_pktValid <= 1'b0;
                        r_pktType  <= T_NONE;
                        r_cnt      <= 7'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 7'd0;
                end
            endcase
        end
    end

    assign o_pkt_type  = r_pktType;
    assign o_data      = r_data;
    assign o_token     = r_token;
    assign o_hshake    = r_hshake;
    assign o_pkt_valid = r_pktValid;
    assign o_pkt_err   = r_pktErr;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bs_decoder.sv
// Self-checking bench for bs_decoder: a packet vector table plus directed
// sequences for truncation, overlong, overrun and mid-packet reset.
module tb_bs_decoder;

    logic        clk;
    logic        rst_n;
    logic        i_s_in;
    logic        i_bit_valid;
    logic        i_eop;
    logic        i_pkt_ack;
    logic [1:0]  o_pkt_type;
    logic [87:0] o_data;
    logic [23:0] o_token;
    logic [7:0]  o_hshake;
    logic        o_pkt_valid;
    logic        o_pkt_err;
    logic        o_overrun;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;
    int errCount = 0;
    int ovrCount = 0;
    bit gapsOn   = 1'b1;

    typedef struct {
        logic [87:0] bits;
        int          nBits;
        logic [1:0]  expType;
        logic [87:0] expField;
        logic        expErr;
    } vec_t;

    vec_t vecs[9];

    bs_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s_in     (i_s_in),
        .i_bit_valid(i_bit_valid),
        .i_eop      (i_eop),
        .i_pkt_ack  (i_pkt_ack),
        .o_pkt_type (o_pkt_type),
        .o_data     (o_data),
        .o_token    (o_token),
        .o_hshake   (o_hshake),
        .o_pkt_valid(o_pkt_valid),
        .o_pkt_err  (o_pkt_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse outputs are tallied on the falling edge, away from the register updates.
    always @(negedge clk) begin
        if (o_pkt_err) errCount++;
        if (o_overrun) ovrCount++;
    end

    task automatic checkOutput(input string name, input logic [87:0] actual, input logic [87:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic driveCycle(input logic s, input logic bv, input logic e, input logic ack);
        i_s_in      = s;
        i_bit_valid = bv;
        i_eop       = e;
        i_pkt_ack   = ack;
        @(posedge clk);
        #1;
        i_bit_valid = 1'b0;
        i_eop       = 1'b0;
        i_pkt_ack   = 1'b0;
    endtask

    task automatic sendBit(input logic b);
        if (gapsOn) begin
            repeat ($urandom_range(0, 2)) driveCycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        driveCycle(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
    endtask

    task automatic sendSync();
        sendByte(8'h80);
    endtask

    task automatic applyStimulus(input vec_t v, input logic eopWithLast);
        sendSync();
        for (int i = 0; i < v.nBits - 1; i++) sendBit(v.bits[i]);
        if (eopWithLast) begin
            driveCycle(v.bits[v.nBits-1], 1'b1, 1'b1, 1'b0);
        end else begin
            driveCycle(v.bits[v.nBits-1], 1'b1, 1'b0, 1'b0);
            if (!v.expErr) begin
                checkOutput("valid_before_eop", {87'd0, o_pkt_valid}, 88'd0);
                checkOutput("busy_in_eopw", {87'd0, o_busy}, 88'd1);
            end
            driveCycle(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    function automatic logic [87:0] fieldOf(input logic [1:0] t);
        case (t)
            2'b11:   fieldOf = {80'd0, o_hshake};
            2'b10:   fieldOf = {64'd0, o_token};
            2'b01:   fieldOf = o_data;
            default: fieldOf = 88'd0;
        endcase
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, {87'd0, o_pkt_valid}, 88'd0);
        checkOutput({tag, "_type"}, {86'd0, o_pkt_type}, 88'd0);
        checkOutput({tag, "_busy"}, {87'd0, o_busy}, 88'd0);
    endtask

    initial begin
        int errBefore;
        int ovrBefore;
        logic [23:0] savedToken;

        vecs[0] = '{bits: {80'd0, 8'hD2}, nBits: 8, expType: 2'b11, expField: {80'd0, 8'hD2}, expErr: 1'b0};
        vecs[1] = '{bits: {80'd0, 8'h5A}, nBits: 8, expType: 2'b11, expField: {80'd0, 8'h5A}, expErr: 1'b0};
        vecs[2] = '{bits: {64'd0, 5'h0A, 4'd4, 7'd5, 8'hE1}, nBits: 24, expType: 2'b10,
                    expField: {64'd0, 5'h0A, 4'd4, 7'd5, 8'hE1}, expErr: 1'b0};
        vecs[3] = '{bits: {64'd0, 5'h1F, 4'hF, 7'h7F, 8'h2D}, nBits: 24, expType: 2'b10,
                    expField: {64'd0, 5'h1F, 4'hF, 7'h7F, 8'h2D}, expErr: 1'b0};
        vecs[4] = '{bits: {16'hBEEF, 64'h0123456789ABCDEF, 8'hC3}, nBits: 88, expType: 2'b01,
                    expField: {16'hBEEF, 64'h0123456789ABCDEF, 8'hC3}, expErr: 1'b0};
        vecs[5] = '{bits: {16'h1234, 64'hFFFF0000AAAA5555, 8'h4B}, nBits: 88, expType: 2'b01,
                    expField: {16'h1234, 64'hFFFF0000AAAA5555, 8'h4B}, expErr: 1'b0};
        vecs[6] = '{bits: {80'd0, 8'hE2}, nBits: 8, expType: 2'b00, expField: 88'd0, expErr: 1'b1};
        vecs[7] = '{bits: {80'd0, 8'hF0}, nBits: 8, expType: 2'b00, expField: 88'd0, expErr: 1'b1};
        vecs[8] = '{bits: {64'd0, 5'h11, 4'h3, 7'h2A, 8'h69}, nBits: 24, expType: 2'b10,
                    expField: {64'd0, 5'h11, 4'h3, 7'h2A, 8'h69}, expErr: 1'b0};

        rst_n = 1'b0;
        i_s_in = 1'b0;
        i_bit_valid = 1'b0;
        i_eop = 1'b0;
        i_pkt_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        checkOutput("reset_data", o_data, 88'd0);
        checkOutput("reset_token", {64'd0, o_token}, 88'd0);
        checkOutput("reset_hshake", {80'd0, o_hshake}, 88'd0);
        rst_n = 1'b1;
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkIdleOutputs("post_reset");

        for (int i = 0; i < 9; i++) begin
            errBefore = errCount;
            applyStimulus(vecs[i], 1'(i % 2));
            if (!vecs[i].expErr) begin
                checkOutput($sformatf("v%0d_valid", i), {87'd0, o_pkt_valid}, 88'd1);
                checkOutput($sformatf("v%0d_type", i), {86'd0, o_pkt_type}, {86'd0, vecs[i].expType});
                checkOutput($sformatf("v%0d_field", i), fieldOf(vecs[i].expType), vecs[i].expField);
                driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
                checkOutput($sformatf("v%0d_held", i), {87'd0, o_pkt_valid}, 88'd1);
                driveCycle(1'b0, 1'b0, 1'b0, 1'b1);
                checkIdleOutputs($sformatf("v%0d_ack", i));
            end else begin
                driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
                checkIdleOutputs($sformatf("v%0d_err", i));
            end
            checkOutput($sformatf("v%0d_errcnt", i), 88'(errCount - errBefore), {87'd0, vecs[i].expErr});
        end

        // Token cut short after 12 body bits.
        errBefore = errCount;
        sendSync();
        sendByte(8'hE1);
        for (int i = 0; i < 12; i++) sendBit(1'b1);
        driveCycle(1'b0, 1'b0, 1'b1, 1'b0);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("trunc_errcnt", 88'(errCount - errBefore), 88'd1);
        checkIdleOutputs("trunc");

        // Handshake followed by a stray bit before eop.
        errBefore = errCount;
        sendSync();
        sendByte(8'hD2);
        sendBit(1'b1);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("overlong_errcnt", 88'(errCount - errBefore), 88'd1);
        checkOutput("overlong_busy", {87'd0, o_busy}, 88'd0);
        driveCycle(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("overlong_novalid", {87'd0, o_pkt_valid}, 88'd0);

        // A new packet arriving while an ACK is still held.
        gapsOn = 1'b0;
        savedToken = o_token;
        sendSync();
        sendByte(8'hD2);
        driveCycle(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ovr_hold_valid", {87'd0, o_pkt_valid}, 88'd1);
        ovrBefore = ovrCount;
        errBefore = errCount;
        sendSync();
        sendByte(8'hE1);
        sendByte(8'h55);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_count", 88'(ovrCount - ovrBefore), 88'd24);
        checkOutput("ovr_valid", {87'd0, o_pkt_valid}, 88'd1);
        checkOutput("ovr_type", {86'd0, o_pkt_type}, 88'd3);
        checkOutput("ovr_hshake", {80'd0, o_hshake}, {80'd0, 8'hD2});
        checkOutput("ovr_token", {64'd0, o_token}, {64'd0, savedToken});
        checkOutput("ovr_noerr", 88'(errCount - errBefore), 88'd0);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1);
        checkIdleOutputs("ovr_ack");
        gapsOn = 1'b1;

        // Reset asserted in the middle of a data body.
        sendSync();
        sendByte(8'hC3);
        for (int i = 0; i < 20; i++) sendBit(1'(i % 3 == 0));
        checkOutput("midrst_busy_before", {87'd0, o_busy}, 88'd1);
        #2;
        rst_n = 1'b0;
        #2;
        checkIdleOutputs("midrst");
        checkOutput("midrst_data", o_data, 88'd0);
        checkOutput("midrst_token", {64'd0, o_token}, 88'd0);
        checkOutput("midrst_hshake", {80'd0, o_hshake}, 88'd0);
        checkOutput("midrst_pulses", {86'd0, o_pkt_err, o_overrun}, 88'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Decoder must work normally after the mid-packet reset.
        applyStimulus(vecs[0], 1'b0);
        checkOutput("post_rst_type", {86'd0, o_pkt_type}, 88'd3);
        checkOutput("post_rst_hshake", {80'd0, o_hshake}, {80'd0, 8'hD2});
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1);
        checkIdleOutputs("post_rst_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
